// File: rtl/mvu_host_xfer.sv
// Host-side transfer engine for the MVU array controller port.
// It runs one command at a time. A WRITE broadcasts in_word into every MVU
// selected by a mask, using the shared wrc_* bus. A READ fetches words from
// one MVU through rdc_* and streams them out through a 2-entry FIFO.
module mvu_host_xfer #(
    parameter int NMVU    = 8,
    parameter int N       = 64,
    parameter int BDBANKA = 14,
    parameter int BLEN    = 15,
    localparam int BMVUA   = (NMVU > 1) ? $clog2(NMVU) : 1,
    localparam int BDBANKW = 2 * N
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_dir,
    input  logic [NMVU-1:0]           cmd_mask,
    input  logic [BMVUA-1:0]          cmd_sel,
    input  logic [BDBANKA-1:0]        cmd_addr,
    input  logic [BLEN-1:0]           cmd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BDBANKW-1:0]        in_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BDBANKW-1:0]        out_word,
    output logic [NMVU-1:0]           wrc_en,
    input  logic [NMVU-1:0]           wrc_grnt,
    output logic [BDBANKA-1:0]        wrc_addr,
    output logic [BDBANKW-1:0]        wrc_word,
    output logic [NMVU-1:0]           rdc_en,
    input  logic [NMVU-1:0]           rdc_grnt,
    output logic [NMVU*BDBANKA-1:0]   rdc_addr,
    input  logic [NMVU*BDBANKW-1:0]   rdc_word,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Control state
    state_t               r_state;
    logic                 r_done;
    logic [NMVU-1:0]      r_mask;
    logic [BMVUA-1:0]     r_sel;
    logic [BDBANKA-1:0]   r_addr;
    logic [BLEN-1:0]      r_count;

    // Write path: one-word holding register plus the set of MVUs still owing a grant
    logic                 r_full;
    logic [NMVU-1:0]      r_pending;
    logic [BDBANKW-1:0]   r_word;

    // Read path: 2-entry FIFO and a flag for the read granted last cycle
    logic [BDBANKW-1:0]   r_fifo [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_occ;
    logic                 r_inflight;

    logic                 w_accept;
    logic                 w_retire;
    logic                 w_load;
    logic                 w_pop;
    logic [2:0]           w_level;
    logic                 w_rd_req;
    logic                 w_rd_grant;
    logic [BDBANKW-1:0]   w_rd_data;

    assign w_accept = cmd_valid && cmd_ready;

    // A word retires once every targeted MVU has granted (immediately for an empty mask).
    assign w_retire = (r_state == S_WR) && r_full && ((r_pending & ~wrc_grnt) == '0);

    // Accept a new word if the register is free, or frees up this cycle, and
    // words remain to be loaded. r_count still includes the word in the register.
    assign in_ready = (r_state == S_WR) &&
                      ((!r_full && (r_count != '0)) || (w_retire && (r_count > BLEN'(1))));
    assign w_load   = in_valid && in_ready;

    assign wrc_en   = r_pending;
    assign wrc_addr = r_addr;
    assign wrc_word = r_word;

    assign out_valid = (r_occ != 2'd0);
    assign out_word  = r_fifo[r_rptr];
    assign w_pop     = out_valid && out_ready;

    // Slots committed after this cycle. A new read is issued only if its data
    // will have room when it lands. Counting this cycle's pop sustains full rate.
    assign w_level    = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_req   = (r_state == S_RD) && (r_count != '0) && (w_level < 3'd2);
    assign rdc_en     = w_rd_req ? (NMVU'(1) << r_sel) : '0;
    assign w_rd_grant = w_rd_req && rdc_grnt[r_sel];
    assign w_rd_data  = rdc_word[r_sel*BDBANKW +: BDBANKW];
    assign rdc_addr   = {NMVU{r_addr}};

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign cmd_ready = (r_state == S_IDLE) && !r_done && !rst;

    // Command FSM, address/count bookkeeping and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_mask     <= '0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_pending  <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mask  <= cmd_mask;
                        r_sel   <= cmd_sel;
                        r_addr  <= cmd_addr;
                        r_count <= cmd_len;
                        if (cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= cmd_dir ? S_RD : S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (w_retire) begin
                        r_addr  <= r_addr + BDBANKA'(1);
                        r_count <= r_count - BLEN'(1);
                        if (r_count == BLEN'(1)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    if (w_load) begin
                        r_full    <= 1'b1;
                        r_pending <= r_mask;
                    end else if (w_retire) begin
                        r_full    <= 1'b0;
                        r_pending <= '0;
                    end else begin
                        r_pending <= r_pending & ~wrc_grnt;
                    end
                end
                S_RD: begin
                    if (w_rd_grant) begin
                        r_addr  <= r_addr + BDBANKA'(1);
                        r_count <= r_count - BLEN'(1);
                        if (r_count == BLEN'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            r_inflight <= w_rd_grant;
            if (r_inflight) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

    // Data-only registers: write holding word and FIFO storage
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_word <= in_word;
        end
        if (r_inflight) begin
            r_fifo[r_wptr] <= w_rd_data;
        end
    end

endmodule
